// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and 32x32 register file.
//   Selects the write-back word (ALU result, load data or link address), commits it to the
//   register array, provides two combinational read ports for ID, and counts committed writes.
// Configuration macro: REGFILE_BYPASS_EN
//   defined   -> write-through bypass: a read of the register being committed this cycle
//                returns wb_data_out in the same cycle.
//   undefined -> reads always return the stored array value.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   reg_write_in           write enable from MEM/WB
//   mem_to_reg_in[1:0]     00 ALU, 01 memory, 10 link (PC+4), 11 reserved (no write)
//   data_from_memory_in    load data
//   alu_result_in          ALU result
//   write_reg_in           destination index
//   adder1_in              PC+4 link value
//   read_reg1/2            ID read indices
//   read_data1/2           ID read data (combinational)
//   wb_data_out            selected write-back data (combinational)
//   wb_commit_out          write committed this cycle (combinational)
//   wb_count_out           committed writes since reset (registered, wraps)
module wb_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        reg_write_in,
  input  logic [1:0]                  mem_to_reg_in,
  input  logic [DATA_W-1:0]           data_from_memory_in,
  input  logic [DATA_W-1:0]           alu_result_in,
  input  logic [$clog2(NUM_REGS)-1:0] write_reg_in,
  input  logic [DATA_W-1:0]           adder1_in,
  input  logic [$clog2(NUM_REGS)-1:0] read_reg1,
  input  logic [$clog2(NUM_REGS)-1:0] read_reg2,
  output logic [DATA_W-1:0]           read_data1,
  output logic [DATA_W-1:0]           read_data2,
  output logic [DATA_W-1:0]           wb_data_out,
  output logic                        wb_commit_out,
  output logic [CNT_W-1:0]            wb_count_out
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [CNT_W-1:0]  count_q, count_d;

  // Write-back data select; the reserved encoding yields zero.
  always_comb begin
    wb_data_out = '0;
    case (mem_to_reg_in)
      2'b00:   wb_data_out = alu_result_in;
      2'b01:   wb_data_out = data_from_memory_in;
      2'b10:   wb_data_out = adder1_in;
      default: wb_data_out = '0;
    endcase
  end

  assign wb_commit_out = reg_write_in && (write_reg_in != '0) && (mem_to_reg_in != 2'b11);

  always_comb begin
    regs_d  = regs_q;
    count_d = count_q;
    if (wb_commit_out) begin
      regs_d[write_reg_in] = wb_data_out;
      count_d              = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Reset wins over a simultaneous commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      count_q <= count_d;
    end
  end

  assign wb_count_out = count_q;

  // Read ports: $0 is forced to zero ahead of any bypass.
  always_comb begin
    read_data1 = regs_q[read_reg1];
    read_data2 = regs_q[read_reg2];
`ifdef REGFILE_BYPASS_EN
    if (wb_commit_out && (read_reg1 == write_reg_in)) read_data1 = wb_data_out;
    if (wb_commit_out && (read_reg2 == write_reg_in)) read_data2 = wb_data_out;
`endif
    if (read_reg1 == IdxW'(0)) read_data1 = '0;
    if (read_reg2 == IdxW'(0)) read_data2 = '0;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: a main instance with default widths and a second instance with a
// 4-bit commit counter (same stimulus) so the counter wrap is reached in a few cycles.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_in;
  logic [1:0]  mem_to_reg_in;
  logic [31:0] data_from_memory_in, alu_result_in, adder1_in;
  logic [4:0]  write_reg_in, read_reg1, read_reg2;
  logic [31:0] read_data1, read_data2, wb_data_out;
  logic        wb_commit_out;
  logic [31:0] wb_count_out;
  logic [31:0] s_rd1, s_rd2, s_wb;
  logic        s_commit;
  logic [3:0]  s_count;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference state: architectural registers and an unbounded commit tally.
  logic [31:0] mdl [32];
  longint      mdl_cnt;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .data_from_memory_in(data_from_memory_in), .alu_result_in(alu_result_in),
    .write_reg_in(write_reg_in), .adder1_in(adder1_in), .read_reg1(read_reg1),
    .read_reg2(read_reg2), .read_data1(read_data1), .read_data2(read_data2),
    .wb_data_out(wb_data_out), .wb_commit_out(wb_commit_out), .wb_count_out(wb_count_out)
  );

  wb_regfile #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .data_from_memory_in(data_from_memory_in), .alu_result_in(alu_result_in),
    .write_reg_in(write_reg_in), .adder1_in(adder1_in), .read_reg1(read_reg1),
    .read_reg2(read_reg2), .read_data1(s_rd1), .read_data2(s_rd2),
    .wb_data_out(s_wb), .wb_commit_out(s_commit), .wb_count_out(s_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_wb();
    case (mem_to_reg_in)
      2'd0:    return alu_result_in;
      2'd1:    return data_from_memory_in;
      2'd2:    return adder1_in;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_commit();
    return reg_write_in && write_reg_in != 5'd0 && mem_to_reg_in != 2'd3;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (exp_commit() && idx == write_reg_in) return exp_wb();
`endif
    return mdl[idx];
  endfunction

  // Model update at the clock edge using the inputs held over the preceding cycle.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      mdl_cnt = 0;
    end else if (exp_commit()) begin
      mdl[write_reg_in] = exp_wb();
      mdl_cnt++;
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rd1", read_data1, exp_rd(read_reg1));
      check("rd2", read_data2, exp_rd(read_reg2));
      check("wb_data", wb_data_out, exp_wb());
      check("commit", {31'h0, wb_commit_out}, {31'h0, exp_commit()});
      check("count", wb_count_out, 32'(mdl_cnt));
      check("s_rd1", s_rd1, exp_rd(read_reg1));
      check("s_rd2", s_rd2, exp_rd(read_reg2));
      check("s_count", {28'h0, s_count}, {28'h0, 4'(mdl_cnt)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write_in = 1'b0; mem_to_reg_in = 2'd0; data_from_memory_in = '0;
    alu_result_in = '0; adder1_in = '0; write_reg_in = '0;
  endtask

  initial begin
    rst = 1'b1; read_reg1 = '0; read_reg2 = '0;
    idle();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // 1: every index reads zero after reset.
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i); read_reg2 = 5'(31 - i);
      @(negedge clk);
      check("rst_rd1", read_data1, 32'h0);
      check("rst_rd2", read_data2, 32'h0);
      tick();
    end
    check("rst_count", wb_count_out, 32'h0);

    // 2: ALU write, visible next cycle.
    reg_write_in = 1'b1; mem_to_reg_in = 2'd0; alu_result_in = 32'h1234_5678; write_reg_in = 5'd5;
    tick();
    idle(); read_reg1 = 5'd5;
    @(negedge clk);
    check("t2_rd1", read_data1, 32'h1234_5678);
    check("t2_count", wb_count_out, 32'd1);
    tick();

    // 3: same-cycle read of the register being committed.
    reg_write_in = 1'b1; mem_to_reg_in = 2'd1; data_from_memory_in = 32'hDEAD_BEEF;
    write_reg_in = 5'd7; read_reg2 = 5'd7;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    check("t3_same", read_data2, 32'hDEAD_BEEF);
`else
    check("t3_same", read_data2, 32'h0);
`endif
    tick();
    idle();
    @(negedge clk);
    check("t3_next", read_data2, 32'hDEAD_BEEF);
    tick();

    // 4: writes to $0 and with the reserved select are dropped and not counted.
    reg_write_in = 1'b1; mem_to_reg_in = 2'd2; adder1_in = 32'h40; write_reg_in = 5'd0;
    read_reg1 = 5'd0;
    @(negedge clk);
    check("t4_wb0", wb_data_out, 32'h40);
    check("t4_c0", {31'h0, wb_commit_out}, 32'h0);
    tick();
    mem_to_reg_in = 2'd3; write_reg_in = 5'd3; read_reg2 = 5'd3;
    @(negedge clk);
    check("t4_wb3", wb_data_out, 32'h0);
    check("t4_c3", {31'h0, wb_commit_out}, 32'h0);
    tick();
    idle();
    @(negedge clk);
    check("t4_r0", read_data1, 32'h0);
    check("t4_r3", read_data2, 32'h0);
    check("t4_count", wb_count_out, 32'd2);
    tick();

    // 5: reset beats a simultaneous commit, then the same commit without reset.
    reg_write_in = 1'b1; mem_to_reg_in = 2'd2; adder1_in = 32'h0040_0008; write_reg_in = 5'd31;
    rst = 1'b1; read_reg1 = 5'd31; read_reg2 = 5'd5;
    tick();
    rst = 1'b0; idle();
    @(negedge clk);
    check("t5_r31", read_data1, 32'h0);
    check("t5_r5", read_data2, 32'h0);
    check("t5_count", wb_count_out, 32'h0);
    reg_write_in = 1'b1; mem_to_reg_in = 2'd2; adder1_in = 32'h0040_0008; write_reg_in = 5'd31;
    tick();
    idle();
    @(negedge clk);
    check("t5_set", read_data1, 32'h0040_0008);
    check("t5_count1", wb_count_out, 32'd1);

    // 6: 15 more commits -> 16 total; the 4-bit counter wraps to zero.
    for (int i = 0; i < 15; i++) begin
      reg_write_in = 1'b1; mem_to_reg_in = 2'd0; alu_result_in = 32'hC000_0000 + 32'(i);
      write_reg_in = 5'(i + 1);
      tick();
    end
    idle();
    @(negedge clk);
    check("t6_count", wb_count_out, 32'd16);
    check("t6_wrap", {28'h0, s_count}, 32'h0);
    tick();

    // Mixed traffic checked cycle by cycle against the model.
    for (int i = 0; i < 40; i++) begin
      reg_write_in        = (i % 5) != 4;
      mem_to_reg_in       = 2'(i);
      alu_result_in       = 32'hA000_0000 + 32'(i);
      data_from_memory_in = ~(32'h0101_0101 * 32'(i));
      adder1_in           = 32'(i) * 32'd4;
      read_reg2           = write_reg_in;
      write_reg_in        = 5'((i * 7) % 32);
      read_reg1           = write_reg_in;
      tick();
    end
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
